quant_scheduler: RTL and testbench
==================================

QUANT_SCHEDULER -- requirements
Module: quant_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 32: maximum cycles from q_start to q_done before abort.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the completed-block counter.
REQ-003 The block SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port clr  input  1  synchronous soft clear.
REQ-006 The block SHALL have port mode  input  1  arbitration mode: 0 = round-robin; 1 = fixed 4:2:0 MCU order.
REQ-007 The block SHALL have port req  input  3  block-ready requests: bit0 = Y, bit1 = Cb, bit2 = Cr.
REQ-008 The block SHALL have port gnt  output  3  one-hot grant pulse; the requester's block is taken.
REQ-009 The block SHALL have port q_start  output  1  start pulse to the shared quantizer.
REQ-010 The block SHALL have port q_sel  output  2  granted channel, 0..2; drives the pixel mux.
REQ-011 The block SHALL have port q_luma  output  1  quantizer table select: 1 when q_sel == 0, else 0.
REQ-012 The block SHALL have port q_done  input  1  single-cycle completion pulse from the quantizer.
REQ-013 The block SHALL have port out_valid  output  1  quantized block available.
REQ-014 The block SHALL have port out_ch  output  2  channel of the available block.
REQ-015 The block SHALL have port out_ready  input  1  downstream accepts the block.
REQ-016 The block SHALL have port blk_cnt  output  CNT_W  count of blocks accepted downstream.
REQ-017 The block SHALL have port err  output  1  sticky timeout flag.
REQ-018 The block SHALL have port err_ch  output  2  channel active at the last timeout.

Function
REQ-019 The FSM SHALL have states IDLE, START, BUSY and HOLD.
REQ-020 IDLE: if an eligible request exists, the block SHALL latch the winner into q_sel and go to START; otherwise it stays in IDLE.
REQ-021 START: the block SHALL assert gnt[q_sel] and q_start for exactly one cycle, clear the watchdog, then go to BUSY.
REQ-022 BUSY: the watchdog SHALL increment each cycle.
- q_done → HOLD.
- Watchdog reaches TIMEOUT-1 without q_done → set err, load err_ch = q_sel, go to IDLE with no out_valid.
REQ-023 If q_done and the timeout coincide, q_done SHALL win; the block goes to HOLD and err is unchanged.
REQ-024 HOLD: out_valid SHALL be 1 with out_ch = q_sel; when out_ready = 1, the block SHALL increment blk_cnt and go to IDLE.
REQ-025 out_valid and out_ch SHALL stay stable until accepted.
REQ-026 blk_cnt SHALL wrap modulo 2^CNT_W.
REQ-027 q_done outside BUSY SHALL be ignored.
REQ-028 Mode 0 (round-robin): priority SHALL start at the channel after the last granted channel; after reset the search order is Y, Cb, Cr.
REQ-029 Mode 1 (MCU order): only the channel at sequence pointer mcu_pos SHALL be eligible.
- Sequence for mcu_pos 0..5: Y, Y, Y, Y, Cb, Cr.
- mcu_pos advances on each grant and wraps 5 → 0.
- Other requests wait.
REQ-030 mode SHALL be sampled only in IDLE; a change of mode during START, BUSY or HOLD SHALL take effect at the next arbitration.
REQ-031 A request that drops before its grant SHALL lose eligibility with no side effect.
REQ-032 q_luma SHALL be combinational from q_sel.
REQ-033 All other outputs SHALL be registered.
REQ-034 Grant-to-out_valid latency SHALL be the quantizer latency + 1 cycle; there is exactly one block in flight.
REQ-035 clr SHALL dominate all other inputs.
- FSM → IDLE; mcu_pos, the round-robin pointer, watchdog, err, err_ch and blk_cnt → 0.
- Any in-flight block is dropped; a pending out_valid is withdrawn.

Reset
REQ-036 On rst_n = 0, the block SHALL asynchronously reset to the following values.
- FSM = IDLE.
- gnt = 0, q_start = 0, q_sel = 0, out_valid = 0, out_ch = 0.
- blk_cnt = 0, err = 0, err_ch = 0.
- mcu_pos = 0; round-robin pointer = Cr, so Y has first priority.
REQ-037 Reset asserted mid-operation SHALL abandon the current block without emitting out_valid.

Verification
REQ-038 Round-robin: mode = 0, req = 3'b111 held, q_done 10 cycles after each q_start, out_ready = 1 → grant order Y, Cb, Cr, Y; blk_cnt = 4.
REQ-039 MCU order: mode = 1, req = 3'b111 held → grant sequence Y, Y, Y, Y, Cb, Cr, Y; q_luma = 1 exactly on the Y grants.
REQ-040 Backpressure: out_ready = 0 for 20 cycles after q_done → out_valid and out_ch stable and no new q_start in that window; the block is accepted on the first out_ready = 1.
REQ-041 Timeout: no q_done after a Cb grant → err = 1 and err_ch = 1 at the TIMEOUT boundary (32 cycles); no out_valid; the next grant proceeds normally.
REQ-042 Boundaries:
- q_done coincident with the timeout cycle → HOLD and err = 0.
- clr during BUSY → out_valid never asserts and all counters are 0.
- rst_n pulsed in HOLD → every output is at its reset value immediately.

Source files
------------

// File: rtl/quant_scheduler.sv
// Arbitrates Y/Cb/Cr block-ready requests onto one shared quantizer,
// with a completion watchdog and a registered output handshake.
module quant_scheduler #(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             mode,
  input  logic [2:0]       req,
  output logic [2:0]       gnt,
  output logic             q_start,
  output logic [1:0]       q_sel,
  output logic             q_luma,
  input  logic             q_done,
  output logic             out_valid,
  output logic [1:0]       out_ch,
  input  logic             out_ready,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             err,
  output logic [1:0]       err_ch
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    HOLD
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [WD_W-1:0] wd;
  logic [1:0]      rr_last;
  logic [2:0]      mcu_pos;

  logic       found;
  logic [1:0] win;
  logic [1:0] mcu_ch;
  logic [1:0] c1, c2, c3;

  function automatic logic [1:0] nxt(input logic [1:0] c);
    return (c >= 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  assign q_luma = (q_sel == 2'd0);

  always_comb begin
    found  = 1'b0;
    win    = 2'd0;
    c1     = nxt(rr_last);
    c2     = nxt(c1);
    c3     = nxt(c2);
    mcu_ch = (mcu_pos == 3'd4) ? 2'd1 :
             (mcu_pos == 3'd5) ? 2'd2 : 2'd0;
    if (mode) begin
      found = req[mcu_ch];
      win   = mcu_ch;
    end else if (req[c1]) begin
      found = 1'b1;
      win   = c1;
    end else if (req[c2]) begin
      found = 1'b1;
      win   = c2;
    end else if (req[c3]) begin
      found = 1'b1;
      win   = c3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 3'd0;
      q_start   <= 1'b0;
      q_sel     <= 2'd0;
      out_valid <= 1'b0;
      out_ch    <= 2'd0;
      blk_cnt   <= '0;
      err       <= 1'b0;
      err_ch    <= 2'd0;
      wd        <= '0;
      mcu_pos   <= 3'd0;
      rr_last   <= 2'd2;
    end else if (clr) begin
      state     <= IDLE;
      gnt       <= 3'd0;
      q_start   <= 1'b0;
      out_valid <= 1'b0;
      blk_cnt   <= '0;
      err       <= 1'b0;
      err_ch    <= 2'd0;
      wd        <= '0;
      mcu_pos   <= 3'd0;
      rr_last   <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            q_sel   <= win;
            gnt     <= 3'b001 << win;
            q_start <= 1'b1;
            rr_last <= win;
            if (mode)
              mcu_pos <= (mcu_pos == 3'd5) ? 3'd0 : mcu_pos + 3'd1;
            state   <= START;
          end
        end
        START: begin
          gnt     <= 3'd0;
          q_start <= 1'b0;
          wd      <= '0;
          state   <= BUSY;
        end
        BUSY: begin
          // a completion in the final watchdog cycle still counts
          if (q_done) begin
            out_valid <= 1'b1;
            out_ch    <= q_sel;
            state     <= HOLD;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            err    <= 1'b1;
            err_ch <= q_sel;
            state  <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            blk_cnt   <= blk_cnt + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quant_scheduler.sv
// Randomized bench for quant_scheduler against a transaction-level
// arbitration/completion model.
module tb_quant_scheduler;

  localparam int TO = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          mode;
  logic [2:0]    req;
  logic [2:0]    gnt;
  logic          q_start;
  logic [1:0]    q_sel;
  logic          q_luma;
  logic          q_done;
  logic          out_valid;
  logic [1:0]    out_ch;
  logic          out_ready;
  logic [CW-1:0] blk_cnt;
  logic          err;
  logic [1:0]    err_ch;

  quant_scheduler #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .req(req),
    .gnt(gnt), .q_start(q_start), .q_sel(q_sel), .q_luma(q_luma),
    .q_done(q_done), .out_valid(out_valid), .out_ch(out_ch),
    .out_ready(out_ready), .blk_cnt(blk_cnt), .err(err),
    .err_ch(err_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_last, m_pos, m_cnt, m_err, m_err_ch;
  int glog[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset(input int last);
    m_last = last;
    m_pos = 0;
    m_cnt = 0;
    m_err = 0;
    m_err_ch = 0;
  endtask

  function automatic int mcu_need();
    return (m_pos < 4) ? 0 : m_pos - 3;
  endfunction

  function automatic int exp_ch(input bit md, input logic [2:0] r);
    int c;
    if (md) begin
      c = mcu_need();
      return r[c] ? c : -1;
    end
    for (int i = 1; i <= 3; i++) begin
      c = (m_last + i) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_reset_outs();
    check("rst_gnt", gnt, 0);
    check("rst_q_start", q_start, 0);
    check("rst_q_sel", q_sel, 0);
    check("rst_q_luma", q_luma, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_err", err, 0);
    check("rst_err_ch", err_ch, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the q_start negedge.
  task automatic arb(input bit md, input logic [2:0] r, output int e);
    int n;
    mode = md;
    req = r;
    e = exp_ch(md, r);
    if (e < 0) begin
      repeat (4) begin
        @(negedge clk);
        check("stall_no_start", q_start, 0);
      end
      r = r | (3'b001 << mcu_need());
      req = r;
      e = exp_ch(md, r);
    end
    n = 0;
    @(negedge clk);
    while (!q_start && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", q_start, 1);
    check("gnt", gnt, 3'b001 << e);
    check("q_sel", q_sel, e);
    check("q_luma", q_luma, (e == 0));
    glog.push_back(int'(q_sel));
    m_last = e;
    if (md) m_pos = (m_pos + 1) % 6;
    req = 3'b000;
    mode = ~md;
  endtask

  // d = edge index after START at which q_done is sampled; 0 = never.
  task automatic finish_txn(input int e, input int d, input int bp,
                            input bit spur);
    bit held = 0;
    q_done = spur;
    for (int j = 1; j <= TO + 1; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check("start_pulse", q_start, 0);
        check("gnt_pulse", gnt, 0);
      end
      if (d >= 1 && j == d + 1) begin
        check("done_valid", out_valid, 1);
        check("done_ch", out_ch, e);
        check("done_err", err, m_err);
        held = 1;
        break;
      end else if (j == TO + 1) begin
        check("to_err", err, 1);
        check("to_err_ch", err_ch, e);
        check("to_no_valid", out_valid, 0);
        m_err = 1;
        m_err_ch = e;
        break;
      end
      check("busy_no_valid", out_valid, 0);
      check("busy_err", err, m_err);
      q_done = (j == d);
    end
    q_done = 1'b0;
    if (held) begin
      out_ready = 1'b0;
      for (int k = 0; k < bp; k++) begin
        @(negedge clk);
        check("bp_valid", out_valid, 1);
        check("bp_ch", out_ch, e);
        check("bp_no_start", q_start, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      m_cnt = (m_cnt + 1) % (1 << CW);
      check("acc_valid", out_valid, 0);
      check("acc_cnt", blk_cnt, m_cnt);
    end
    check("err_ch_keep", err_ch, m_err_ch);
  endtask

  task automatic txn(input bit md, input logic [2:0] r, input int d,
                     input int bp, input bit spur);
    int e;
    arb(md, r, e);
    finish_txn(e, d, bp, spur);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got expired want finished");
    $fatal(1);
  end

  initial begin
    int e;
    logic [2:0] r;
    int d;
    rst_n = 1'b0;
    clr = 1'b0;
    mode = 1'b0;
    req = 3'b000;
    q_done = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs();
    rst_n = 1'b1;
    m_reset(2);
    @(negedge clk);

    glog.delete();
    repeat (4) txn(1'b0, 3'b111, 10, 0, 1'b0);
    check("rr_order0", glog[0], 0);
    check("rr_order1", glog[1], 1);
    check("rr_order2", glog[2], 2);
    check("rr_order3", glog[3], 0);
    check("rr_blk_cnt", blk_cnt, 4);

    glog.delete();
    repeat (7) txn(1'b1, 3'b111, 5, 0, 1'b0);
    check("mcu_order0", glog[0], 0);
    check("mcu_order3", glog[3], 0);
    check("mcu_order4", glog[4], 1);
    check("mcu_order5", glog[5], 2);
    check("mcu_order6", glog[6], 0);

    txn(1'b0, 3'b111, 10, 20, 1'b0);

    glog.delete();
    txn(1'b0, 3'b010, 0, 0, 1'b0);
    check("to_cb_ch", glog[0], 1);
    check("to_sticky_err", err, 1);
    txn(1'b0, 3'b111, 6, 1, 1'b0);
    check("after_to_err", err, 1);

    txn(1'b0, 3'b111, TO, 0, 1'b0);

    q_done = 1'b1;
    @(negedge clk);
    q_done = 1'b0;
    check("idle_done_valid", out_valid, 0);
    check("idle_done_start", q_start, 0);

    arb(1'b0, 3'b111, e);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_reset(0);
    q_done = 1'b1;
    @(negedge clk);
    q_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("clr_no_valid", out_valid, 0);
    end
    check("clr_blk_cnt", blk_cnt, 0);
    check("clr_err", err, 0);
    check("clr_err_ch", err_ch, 0);
    glog.delete();
    txn(1'b0, 3'b111, 4, 0, 1'b0);
    check("clr_rr_next", glog[0], 1);

    arb(1'b0, 3'b100, e);
    @(negedge clk);
    q_done = 1'b1;
    @(negedge clk);
    q_done = 1'b0;
    check("hold_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    m_reset(2);
    glog.delete();
    txn(1'b0, 3'b111, 3, 0, 1'b0);
    check("rst_rr_next", glog[0], 0);

    for (int t = 0; t < 60; t++) begin
      r = 3'($urandom_range(1, 7));
      d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      if ($urandom_range(0, 3) == 0) begin
        q_done = 1'b1;
        @(negedge clk);
        q_done = 1'b0;
        check("rnd_idle_done", out_valid, 0);
      end
      txn(1'(($urandom >> 4) & 1), r, d, $urandom_range(0, 4),
          1'(($urandom >> 7) & 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
